// File: rtl/mastermind_round_ctrl.sv
// mastermind_round_ctrl: round sequencer for two-player Mastermind.
// Turns enterA/enterB presses and letterIn into letter-store writes, runs the
// compare handshake with the scoring datapath, and tracks lives, roles and score.
// Ports:
//   clk, rst (async active-low), enterA/enterB (level buttons), letterIn[2:0]
//   cmp_done/exact_cnt[2:0]  : scorer result handshake
//   wr_en/wr_sel/wr_idx/wr_data : letter store write port (sel 0 code, 1 guess)
//   cmp_start : one-cycle compare request
//   maker, phase[2:0], lives[2:0], score_a/score_b[1:0], fb_exact[2:0], err
module mastermind_round_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned WIN_SCORE   = 2,
  parameter int unsigned SHOW_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enterA,
  input  logic       enterB,
  input  logic [2:0] letterIn,
  input  logic       cmp_done,
  input  logic [2:0] exact_cnt,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [1:0] wr_idx,
  output logic [2:0] wr_data,
  output logic       cmp_start,
  output logic       maker,
  output logic [2:0] phase,
  output logic [2:0] lives,
  output logic [1:0] score_a,
  output logic [1:0] score_b,
  output logic [2:0] fb_exact,
  output logic       err
);

  localparam logic [2:0] PH_IDLE      = 3'd0;
  localparam logic [2:0] PH_CODE      = 3'd1;
  localparam logic [2:0] PH_GUESS     = 3'd2;
  localparam logic [2:0] PH_CMP       = 3'd3;
  localparam logic [2:0] PH_SHOW      = 3'd4;
  localparam logic [2:0] PH_ROUND_END = 3'd5;
  localparam logic [2:0] PH_OVER      = 3'd6;

  localparam int unsigned     CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
  localparam logic [1:0]      WIN_L      = 2'(WIN_SCORE);

  logic             enter_a_d, enter_b_d;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       phase_n, lives_n, fb_exact_n, wr_data_n;
  logic [1:0]       idx_n, score_a_n, score_b_n, wr_idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic             maker_n, wr_en_n, wr_sel_n, cmp_start_n, err_n;

  logic press_a, press_b, maker_press, breaker_press, accepted, letter_ok;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  // Rising-edge press detection and role mapping
  always_comb begin
    press_a       = enterA & ~enter_a_d;
    press_b       = enterB & ~enter_b_d;
    maker_press   = maker ? press_b : press_a;
    breaker_press = maker ? press_a : press_b;
    accepted      = (phase == PH_CODE) ? maker_press : breaker_press;
    letter_ok     = (letterIn != 3'b111);
  end

  // Next-state and registered-output logic
  always_comb begin
    phase_n     = phase;
    idx_n       = idx;
    lives_n     = lives;
    score_a_n   = score_a;
    score_b_n   = score_b;
    fb_exact_n  = fb_exact;
    maker_n     = maker;
    cnt_n       = cnt;
    wr_en_n     = 1'b0;
    wr_sel_n    = wr_sel;
    wr_idx_n    = wr_idx;
    wr_data_n   = wr_data;
    cmp_start_n = 1'b0;
    err_n       = 1'b0;

    case (phase)
      PH_IDLE: begin
        if (press_a || press_b) begin
          maker_n = 1'b0;
          lives_n = LIVES_INIT;
          idx_n   = 2'd0;
          phase_n = PH_CODE;
        end
      end

      PH_CODE, PH_GUESS: begin
        if (wr_en) begin
          // The write issued last cycle commits here: advance idx / phase.
          if (idx == 2'd3) begin
            idx_n = 2'd0;
            if (phase == PH_CODE) begin
              phase_n = PH_GUESS;
            end else begin
              phase_n     = PH_CMP;
              cmp_start_n = 1'b1;
            end
          end else begin
            idx_n = idx + 2'd1;
          end
        end else if (accepted) begin
          if (letter_ok) begin
            wr_en_n   = 1'b1;
            wr_sel_n  = (phase == PH_GUESS);
            wr_idx_n  = idx;
            wr_data_n = letterIn;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      PH_CMP: begin
        if (cmp_done) begin
          // Out-of-range results are scored as a near miss, never a win.
          fb_exact_n = (exact_cnt > 3'd4) ? 3'd3 : exact_cnt;
          cnt_n      = CNT_LOAD;
          phase_n    = PH_SHOW;
        end
      end

      PH_SHOW: begin
        if (cnt == '0) begin
          if (fb_exact == 3'd4) begin
            if (maker) score_a_n = sat_inc(score_a);
            else       score_b_n = sat_inc(score_b);
            cnt_n   = CNT_LOAD;
            phase_n = PH_ROUND_END;
          end else begin
            lives_n = lives - 3'd1;
            if (lives <= 3'd1) begin
              if (maker) score_b_n = sat_inc(score_b);
              else       score_a_n = sat_inc(score_a);
              cnt_n   = CNT_LOAD;
              phase_n = PH_ROUND_END;
            end else begin
              idx_n   = 2'd0;
              phase_n = PH_GUESS;
            end
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      PH_ROUND_END: begin
        if (cnt == '0) begin
          if ((score_a >= WIN_L) || (score_b >= WIN_L)) begin
            phase_n = PH_OVER;
          end else begin
            maker_n = ~maker;
            lives_n = LIVES_INIT;
            idx_n   = 2'd0;
            phase_n = PH_CODE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      PH_OVER: begin
        if (press_a) begin
          score_a_n  = 2'd0;
          score_b_n  = 2'd0;
          maker_n    = 1'b0;
          fb_exact_n = 3'd0;
          phase_n    = PH_IDLE;
        end
      end

      default: phase_n = PH_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= PH_IDLE;
      idx       <= 2'd0;
      lives     <= LIVES_INIT;
      score_a   <= 2'd0;
      score_b   <= 2'd0;
      fb_exact  <= 3'd0;
      maker     <= 1'b0;
      cnt       <= '0;
      enter_a_d <= 1'b0;
      enter_b_d <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_idx    <= 2'd0;
      wr_data   <= 3'd0;
      cmp_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      phase     <= phase_n;
      idx       <= idx_n;
      lives     <= lives_n;
      score_a   <= score_a_n;
      score_b   <= score_b_n;
      fb_exact  <= fb_exact_n;
      maker     <= maker_n;
      cnt       <= cnt_n;
      enter_a_d <= enterA;
      enter_b_d <= enterB;
      wr_en     <= wr_en_n;
      wr_sel    <= wr_sel_n;
      wr_idx    <= wr_idx_n;
      wr_data   <= wr_data_n;
      cmp_start <= cmp_start_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Testbench for mastermind_round_ctrl: directed game flow with a strobe
// scoreboard (writes, err, cmp_start) plus direct status checks.
module tb_mastermind_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enterA = 1'b0;
  logic       enterB = 1'b0;
  logic [2:0] letterIn = 3'd0;
  logic       cmp_done = 1'b0;
  logic [2:0] exact_cnt = 3'd0;
  logic       wr_en, wr_sel, cmp_start, maker, err;
  logic [1:0] wr_idx, score_a, score_b;
  logic [2:0] wr_data, phase, lives, fb_exact;

  logic [2:0] next_exact = 3'd0;
  int tests = 0;
  int fails = 0;

  typedef enum logic [1:0] {EV_WR, EV_ERR, EV_CMP} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic       sel;
    logic [1:0] idx;
    logic [2:0] data;
  } ev_t;
  ev_t exp_q[$];

  mastermind_round_ctrl #(.LIVES(3), .WIN_SCORE(2), .SHOW_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .enterA(enterA), .enterB(enterB), .letterIn(letterIn),
    .cmp_done(cmp_done), .exact_cnt(exact_cnt),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .cmp_start(cmp_start), .maker(maker), .phase(phase), .lives(lives),
    .score_a(score_a), .score_b(score_b), .fb_exact(fb_exact), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic s, input logic [1:0] i,
                           input logic [2:0] d);
    ev_t e;
    e.kind = k; e.sel = s; e.idx = i; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_strobe: got kind %0d sel %0d idx %0d data %0d, required none",
               k, wr_sel, wr_idx, wr_data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k ||
          (k == EV_WR && (e.sel != wr_sel || e.idx != wr_idx || e.data != wr_data))) begin
        fails++;
        $display("FAIL strobe: got kind %0d sel %0d idx %0d data %0d, required kind %0d sel %0d idx %0d data %0d",
                 k, wr_sel, wr_idx, wr_data, e.kind, e.sel, e.idx, e.data);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en)     check_ev(EV_WR);
      if (err)       check_ev(EV_ERR);
      if (cmp_start) check_ev(EV_CMP);
    end
  end

  // Scorer model: answer a compare request in the same cycle it is raised.
  always @(negedge clk) begin
    cmp_done = 1'b0;
    if (rst && cmp_start) begin
      cmp_done  = 1'b1;
      exact_cnt = next_exact;
    end
  end

  task automatic press(input bit btn, input logic [2:0] letter);
    @(negedge clk);
    letterIn = letter;
    if (btn) enterB = 1'b1; else enterA = 1'b1;
    @(negedge clk);
    enterA = 1'b0;
    enterB = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic write4(input bit btn, input logic sel, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
    logic [2:0] l [4];
    l[0] = a; l[1] = b; l[2] = c; l[3] = d;
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_WR, sel, 2'(i), l[i]);
      if (sel && i == 3) expect_ev(EV_CMP, 1'b0, 2'd0, 3'd0);
      press(btn, l[i]);
    end
  endtask

  // Waits (bounded) for phase ph, then returns how many cycles it lasts.
  task automatic count_phase(input logic [2:0] ph, input string name, output int n);
    int t = 0;
    n = 0;
    while (phase != ph && t < 500) begin t++; @(negedge clk); end
    chk({name, "_reached"}, int'(phase), int'(ph));
    while (phase == ph && n < 500) begin n++; @(negedge clk); end
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_maker", maker, 0);
    chk("rst_lives", lives, 3);
    chk("rst_scores", {score_a, score_b}, 0);
    chk("rst_fb", fb_exact, 0);
    chk("rst_strobes", {wr_en, cmp_start, err}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Held A press counts once: IDLE -> CODE, no write
    enterA = 1'b1;
    repeat (5) @(negedge clk);
    chk("start_phase", phase, 1);
    chk("start_maker", maker, 0);
    chk("start_lives", lives, 3);
    enterA = 1'b0;
    @(negedge clk);

    // CODE by A, with ignored breaker press and one rejected letter
    expect_ev(EV_WR, 1'b0, 2'd0, 3'd1); press(1'b0, 3'd1);
    press(1'b1, 3'd7);
    expect_ev(EV_WR, 1'b0, 2'd1, 3'd2); press(1'b0, 3'd2);
    expect_ev(EV_ERR, 1'b0, 2'd0, 3'd0); press(1'b0, 3'd7);
    chk("code_mid_phase", phase, 1);
    expect_ev(EV_WR, 1'b0, 2'd2, 3'd0); press(1'b0, 3'd0);
    expect_ev(EV_WR, 1'b0, 2'd3, 3'd3); press(1'b0, 3'd3);
    chk("code_done_phase", phase, 2);

    // Guess 1: two exact, lose a life
    next_exact = 3'd2;
    write4(1'b1, 1'b1, 3'd1, 3'd2, 3'd3, 3'd6);
    count_phase(3'd4, "show1", n);
    chk("show1_len", n, 50);
    chk("g1_phase", phase, 2);
    chk("g1_lives", lives, 2);
    chk("g1_fb", fb_exact, 2);

    // Guess 2: out-of-range result scored as 3
    next_exact = 3'd5;
    write4(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0);
    count_phase(3'd4, "show2", n);
    chk("g2_fb", fb_exact, 3);
    chk("g2_lives", lives, 1);
    chk("g2_phase", phase, 2);

    // Guess 3: last life, maker A wins the round
    next_exact = 3'd1;
    write4(1'b1, 1'b1, 3'd5, 3'd4, 3'd3, 3'd2);
    count_phase(3'd4, "show3", n);
    chk("r1_phase", phase, 5);
    chk("r1_lives", lives, 0);
    chk("r1_score_a", score_a, 1);
    chk("r1_score_b", score_b, 0);
    count_phase(3'd5, "rend1", n);
    chk("rend1_len", n, 50);
    chk("r2_phase", phase, 1);
    chk("r2_maker", maker, 1);
    chk("r2_lives", lives, 3);

    // Round 2: B makes, A (breaker) guesses correctly
    press(1'b0, 3'd1);
    write4(1'b1, 1'b0, 3'd5, 3'd4, 3'd3, 3'd2);
    chk("r2_guess_phase", phase, 2);
    next_exact = 3'd4;
    write4(1'b0, 1'b1, 3'd5, 3'd4, 3'd3, 3'd2);
    count_phase(3'd4, "show4", n);
    chk("show4_len", n, 50);
    chk("r2_end_phase", phase, 5);
    chk("r2_score_a", score_a, 2);
    chk("r2_lives_kept", lives, 3);
    count_phase(3'd5, "rend2", n);
    chk("over_phase", phase, 6);

    // OVER: B ignored, A clears and returns to IDLE
    press(1'b1, 3'd0);
    chk("over_b_phase", phase, 6);
    chk("over_b_score", score_a, 2);
    press(1'b0, 3'd0);
    chk("clr_phase", phase, 0);
    chk("clr_scores", {score_a, score_b}, 0);
    chk("clr_maker", maker, 0);
    chk("clr_fb", fb_exact, 0);

    // Reset during GUESS with idx=2 while a write is in flight
    press(1'b0, 3'd0);
    write4(1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 3'd1);
    expect_ev(EV_WR, 1'b1, 2'd0, 3'd2); press(1'b1, 3'd2);
    expect_ev(EV_WR, 1'b1, 2'd1, 3'd2); press(1'b1, 3'd2);
    chk("pre_rst_phase", phase, 2);
    @(negedge clk);
    letterIn = 3'd4;
    enterB = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_phase", phase, 0);
    chk("arst_lives", lives, 3);
    chk("arst_misc", {maker, cmp_start, err, fb_exact}, 0);
    enterB = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_phase", phase, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
